// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// The SEG_BLINK_EN macro adds a per-digit blink field to the display frame.
package seg_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int BANK_W    = 8;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;
  localparam logic [BANK_W-1:0] SEG_BLANK = 8'h00;
  localparam logic [BANK_W-1:0] SEG_DP    = 8'h80;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  mask;
    logic [7:0]  dp;
`ifdef SEG_BLINK_EN
    logic [7:0]  blink;
`endif
  } frame_t;

  // Power-up frame: every digit dark until the first commit.
  localparam frame_t FRAME_RESET = '{
    data:  32'h0000_0000,
    mask:  8'hFF,
`ifdef SEG_BLINK_EN
    dp:    8'h00,
    blink: 8'h00
`else
    dp:    8'h00
`endif
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_decode = SEG_0;
      4'h1:    seg_decode = SEG_1;
      4'h2:    seg_decode = SEG_2;
      4'h3:    seg_decode = SEG_3;
      4'h4:    seg_decode = SEG_4;
      4'h5:    seg_decode = SEG_5;
      4'h6:    seg_decode = SEG_6;
      4'h7:    seg_decode = SEG_7;
      4'h8:    seg_decode = SEG_8;
      4'h9:    seg_decode = SEG_9;
      4'hA:    seg_decode = SEG_A;
      4'hB:    seg_decode = SEG_B;
      4'hC:    seg_decode = SEG_C;
      4'hD:    seg_decode = SEG_D;
      4'hE:    seg_decode = SEG_E;
      4'hF:    seg_decode = SEG_F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble-to-segment decoder; output is {dp,g,f,e,d,c,b,a}.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0]        nibble_i,
  input  logic              dp_i,
  output logic [BANK_W-1:0] seg_o
);

  assign seg_o = {dp_i, seg_decode(nibble_i)};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Two-bank, four-slot seven-segment scan controller with a shadow/active frame buffer.
// Optional macro SEG_BLINK_EN adds wr_blink and a frame-rate blink phase.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int GUARD = 16
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [31:0]       wr_data,
  input  logic [7:0]        wr_mask,
  input  logic [7:0]        wr_dp,
`ifdef SEG_BLINK_EN
  input  logic [7:0]        wr_blink,
`endif
  output logic [BANK_W-1:0] seg_data_left,
  output logic [BANK_W-1:0] seg_data_right,
  output logic [BANK_W-1:0] seg_cs,
  output logic              frame_done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        slot_q, slot_d;
  frame_t            shadow_q, shadow_d;
  frame_t            active_q, active_d;
  frame_t            wr_frame_s;
  logic              pending_q, pending_d;
  logic              wr_ready_q;
  logic              frame_done_q;
  logic [BANK_W-1:0] seg_cs_q, seg_cs_d;
  logic [BANK_W-1:0] seg_l_q, seg_l_d;
  logic [BANK_W-1:0] seg_r_q, seg_r_d;
  logic              slot_end_s, wrap_s, accept_s, guard_s;
  logic [2:0]        left_idx_s, right_idx_s;
  logic [3:0]        left_nib_s, right_nib_s;
  logic [BANK_W-1:0] left_pat_s, right_pat_s;
  logic              left_dark_s, right_dark_s;
  logic [7:0]        dark_vec_s;

  assign slot_end_s = (div_q == DIV_W'(DIV - 1));
  assign wrap_s     = slot_end_s && (slot_q == 2'd3);
  assign accept_s   = wr_valid && wr_ready_q;

  assign wr_frame_s.data = wr_data;
  assign wr_frame_s.mask = wr_mask;
  assign wr_frame_s.dp   = wr_dp;

`ifdef SEG_BLINK_EN
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  assign wr_frame_s.blink = wr_blink;

  // Blink phase flips once every BLINK_FRAMES frame wraps.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wrap_s) begin
      if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end else begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign dark_vec_s = active_d.mask | (active_d.blink & {8{blink_phase_d}});
`else
  assign dark_vec_s = active_d.mask;
`endif

  // Slot timing: divider wraps at DIV-1 and advances the 2-bit slot counter.
  always_comb begin
    if (slot_end_s) begin
      div_d  = '0;
      slot_d = slot_q + 2'd1;
    end else begin
      div_d  = div_q + DIV_W'(1);
      slot_d = slot_q;
    end
  end

  // Shadow/active handshake; accept and commit are exclusive since ready = !pending.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (accept_s) begin
      shadow_d  = wr_frame_s;
      pending_d = 1'b1;
    end else if (wrap_s && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Outputs are computed from next state so cs and segments move on one edge.
  assign left_idx_s   = 3'd7 - {1'b0, slot_d};
  assign right_idx_s  = 3'd3 - {1'b0, slot_d};
  assign left_nib_s   = active_d.data[{left_idx_s, 2'b00} +: 4];
  assign right_nib_s  = active_d.data[{right_idx_s, 2'b00} +: 4];
  assign left_dark_s  = dark_vec_s[left_idx_s];
  assign right_dark_s = dark_vec_s[right_idx_s];
  assign guard_s      = int'({1'b0, div_d}) < GUARD;

  hex7seg u_hex_left (
    .nibble_i (left_nib_s),
    .dp_i     (active_d.dp[left_idx_s]),
    .seg_o    (left_pat_s)
  );

  hex7seg u_hex_right (
    .nibble_i (right_nib_s),
    .dp_i     (active_d.dp[right_idx_s]),
    .seg_o    (right_pat_s)
  );

  // Output next-state: blank during guard, per-bank blank for dark digits.
  always_comb begin
    if (guard_s) begin
      seg_cs_d = 8'h00;
      seg_l_d  = SEG_BLANK;
      seg_r_d  = SEG_BLANK;
    end else begin
      seg_cs_d = (8'h80 >> slot_d) | (8'h08 >> slot_d);
      seg_l_d  = left_dark_s  ? SEG_BLANK : left_pat_s;
      seg_r_d  = right_dark_s ? SEG_BLANK : right_pat_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      slot_q       <= 2'd0;
      shadow_q     <= FRAME_RESET;
      active_q     <= FRAME_RESET;
      pending_q    <= 1'b0;
      wr_ready_q   <= 1'b1;
      frame_done_q <= 1'b0;
      seg_cs_q     <= 8'h00;
      seg_l_q      <= SEG_BLANK;
      seg_r_q      <= SEG_BLANK;
    end else begin
      div_q        <= div_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      wr_ready_q   <= ~pending_d;
      frame_done_q <= wrap_s;
      seg_cs_q     <= seg_cs_d;
      seg_l_q      <= seg_l_d;
      seg_r_q      <= seg_r_d;
    end
  end

  assign wr_ready       = wr_ready_q;
  assign frame_done     = frame_done_q;
  assign seg_cs         = seg_cs_q;
  assign seg_data_left  = seg_l_q;
  assign seg_data_right = seg_r_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIV, default 100000, clock cycles per scan slot (DIV >= 4).
REQ-002 Parameter GUARD, default 16, blanked cycles at the start of each slot (0 <= GUARD < DIV).
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 wr_valid  in  1  new display frame offered.
REQ-006 wr_ready  out  1  shadow buffer free; write accepted when wr_valid && wr_ready.
REQ-007 wr_data  in  32  eight hex nibbles; nibble 7 = leftmost digit.
REQ-008 wr_mask  in  8  per-digit blank; 1 = digit dark.
REQ-009 wr_dp  in  8  per-digit decimal point; 1 = lit.
REQ-010 seg_data_left  out  8  left-bank segments {dp,g,f,e,d,c,b,a}, active-high.
REQ-011 seg_data_right  out  8  right-bank segments, same encoding.
REQ-012 seg_cs  out  8  digit enables, active-high; bits 7..4 left bank, 3..0 right bank.
REQ-013 frame_done  out  1  one-cycle pulse at each frame wrap.

Function
REQ-014 Divider counts 0..DIV-1; at DIV-1 it wraps and the slot counter (2 bits, 0..3) increments, wrapping 3->0 (frame wrap).
REQ-015 In slot s: seg_cs[7-s] and seg_cs[3-s] high, all other bits low; left bank shows digit 7-s, right bank digit 3-s.
REQ-016 During divider values 0..GUARD-1 of every slot, seg_cs = 8'h00 and both segment buses = 8'h00.
REQ-017 Segment outputs are registered; seg_cs and segment buses change on the same edge (no skew cycle).
REQ-018 Nibble decode: 0..F -> 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex, bits 6..0); bit 7 = dp.
REQ-019 Masked digit drives 8'h00 on its bank during its slot (dp also suppressed); seg_cs still asserted.
REQ-020 Accepted write loads shadow {data,mask,dp} and sets pending; wr_ready = !pending, registered.
REQ-021 At frame wrap with pending set: shadow copied to active buffer, pending cleared, wr_ready high next cycle.
REQ-022 Write accepted in the frame-wrap cycle itself is committed at the following wrap, not the current one.
REQ-023 wr_valid while wr_ready low is ignored; shadow unchanged; no data loss of the already-pending frame.
REQ-024 frame_done asserts for exactly one cycle per wrap, coincident with commit.

Reset
REQ-025 rst_n low: divider 0, slot 0, seg_cs 8'h00, segment buses 8'h00, frame_done 0, pending 0, wr_ready 1, active mask 8'hFF (all dark), active data/dp 0.
REQ-026 Reset mid-slot or mid-handshake discards shadow and pending; scan restarts from slot 0 with GUARD blanking.

Configuration
REQ-027 Macro SEG_BLINK_EN defined: adds input wr_blink[7:0] (captured with the write) and parameter BLINK_FRAMES (default 64); blink phase toggles every BLINK_FRAMES frames, resets to 0; digits with blink bit set are dark while phase = 1.
REQ-028 SEG_BLINK_EN undefined: no wr_blink port, no blink counter, behaviour per REQ-014..024 only.

Structure
REQ-029 Package seg_pkg holds segment encoding constants (18 values), slot count (4), bank width (8) and the display-frame struct {data,mask,dp[,blink]}.
REQ-030 Combinational sub-module hex7seg (4-bit nibble + dp -> 8-bit pattern), instantiated once per bank.

Verification (DIV=8, GUARD=2)
REQ-031 Reset release, no writes -> seg_cs cycles 88,44,22,11 with two 00 guard cycles per slot; segment buses 00 throughout.
REQ-032 Write data=32'h0123_4567, mask=00, dp=01 -> after next wrap slot 0 shows left 3F, right 66; slot 3 shows left 4F, right 87.
REQ-033 Two back-to-back writes -> second held off (wr_ready 0) until wrap; second frame displayed one frame later.
REQ-034 Write coinciding with frame_done cycle -> not visible until the subsequent frame_done.
REQ-035 mask=8'h80 with data=32'hF000_0000 -> slot 0 left bus 00 with seg_cs[7]=1; other digits show 3F.
REQ-036 SEG_BLINK_EN, BLINK_FRAMES=2, blink=8'h01 -> digit 0 alternates lit/dark every 2 frames; rst_n pulse mid-frame -> all outputs 00 asynchronously.
